// File: rtl/sd_cmd_response_rx_pkg.sv
// Shared types and frame layout constants for the SD CMD response receiver.
package sd_cmd_response_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_RECEIVE,
      ST_CHECK
   } rx_state_t;

   typedef struct packed {
      logic       long_response;
      logic       check_crc;
      logic       check_index;
      logic [5:0] expected_index;
   } rx_cfg_t;

   localparam int NCR_MAX_DEF    = 64;
   localparam int SHORT_FRAME_LEN = 48;
   localparam int LONG_FRAME_LEN  = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int END_BIT      = 0;
   localparam int CRC_LO       = 1;
   localparam int CRC_HI       = 7;
   localparam int PAYLOAD_LO   = 8;
   localparam int SHORT_PAY_HI = 39;
   localparam int IDX_LO       = 40;
   localparam int IDX_HI       = 45;
   localparam int LONG_CRC_TOP = 127;

   // transmission bit always sits directly after the start bit
   function automatic logic [7:0] tx_pos(input int len);
      return 8'(len - 2);
   endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Serial CRC7 (x^7 + x^3 + 1) generator/checker, MSB-first.
module sd_crc7_serial
   import sd_cmd_response_rx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[6];

   always_ff @(posedge clk) begin
      if (reset) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (enable) begin
         crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/sd_cmd_response_rx.sv
// SD CMD-line response receiver: start-bit wait, deserialise,
// CRC7/framing/index check, one-cycle done pulse.
module sd_cmd_response_rx
   import sd_cmd_response_rx_pkg::*;
#(
   parameter int NCR_MAX   = NCR_MAX_DEF,
   parameter int SHORT_LEN = SHORT_FRAME_LEN,
   parameter int LONG_LEN  = LONG_FRAME_LEN
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rx_enable,
   input  logic         long_response,
   input  logic         check_crc,
   input  logic         check_index,
   input  logic [5:0]   expected_index,
   input  logic         cmd_in,
   output logic         busy,
   output logic [127:0] response,
   output logic         response_done,
   output logic         timeout_error,
   output logic         crc_error,
   output logic         framing_error,
   output logic         index_error
);

   localparam int WAIT_W = $clog2(NCR_MAX) + 1;

   rx_state_t         state;
   rx_cfg_t           cfg;
   logic [WAIT_W-1:0] wait_cnt;
   logic [7:0]        bit_cnt;
   logic [127:0]      shreg;
   logic              tx_bit;
   logic [6:0]        crc;
   logic              crc_clear;
   logic              crc_en;
   logic [7:0]        frame_top;
   logic [7:0]        crc_top;

   assign frame_top = cfg.long_response ? tx_pos(LONG_LEN)
                                        : tx_pos(SHORT_LEN);
   assign crc_top   = cfg.long_response ? 8'(LONG_CRC_TOP)
                                        : 8'(SHORT_LEN - 1);

   // long frames exclude start/tx/reserved bits from the CRC
   always_comb begin
      crc_clear = 1'b0;
      crc_en    = 1'b0;
      unique case (1'b1)
         state == ST_IDLE:
            crc_clear = rx_enable;
         state == ST_WAIT_START:
            crc_en = !cmd_in && !cfg.long_response;
         state == ST_RECEIVE:
            crc_en = (bit_cnt >= 8'(PAYLOAD_LO))
                  && (bit_cnt <= crc_top);
         default: ;
      endcase
   end

   sd_crc7_serial u_crc (
      .clk    (clk),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_en),
      .bit_in (cmd_in),
      .crc    (crc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         cfg           <= '0;
         wait_cnt      <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         tx_bit        <= 1'b0;
         busy          <= 1'b0;
         response      <= '0;
         response_done <= 1'b0;
         timeout_error <= 1'b0;
         crc_error     <= 1'b0;
         framing_error <= 1'b0;
         index_error   <= 1'b0;
      end else begin
         response_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (rx_enable) begin
                  cfg.long_response  <= long_response;
                  cfg.check_crc      <= check_crc;
                  cfg.check_index    <= check_index;
                  cfg.expected_index <= expected_index;
                  response      <= '0;
                  timeout_error <= 1'b0;
                  crc_error     <= 1'b0;
                  framing_error <= 1'b0;
                  index_error   <= 1'b0;
                  wait_cnt      <= '0;
                  busy          <= 1'b1;
                  state         <= ST_WAIT_START;
               end
            end
            ST_WAIT_START: begin
               if (!cmd_in) begin
                  bit_cnt <= frame_top;
                  state   <= ST_RECEIVE;
               end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
                  timeout_error <= 1'b1;
                  response_done <= 1'b1;
                  busy          <= 1'b0;
                  state         <= ST_IDLE;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RECEIVE: begin
               shreg <= {shreg[126:0], cmd_in};
               if (bit_cnt == frame_top) begin
                  tx_bit <= cmd_in;
               end
               if (bit_cnt == 8'd0) begin
                  state <= ST_CHECK;
               end else begin
                  bit_cnt <= bit_cnt - 8'd1;
               end
            end
            ST_CHECK: begin
               if (cfg.long_response) begin
                  response <= {8'h00,
                     shreg[LONG_CRC_TOP:PAYLOAD_LO]};
               end else begin
                  response <= {96'h0,
                     shreg[SHORT_PAY_HI:PAYLOAD_LO]};
               end
               crc_error <= cfg.check_crc
                  && (crc != shreg[CRC_HI:CRC_LO]);
               framing_error <= tx_bit || !shreg[END_BIT];
               index_error <= cfg.check_index
                  && !cfg.long_response
                  && (shreg[IDX_HI:IDX_LO] != cfg.expected_index);
               response_done <= 1'b1;
               busy          <= 1'b0;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
